// File: rtl/iob_ram_sp_be_rmw.sv
// Single-port byte-enable RAM with per-word even parity; partial writes run as a read-modify-write.
// Optional parity error injection is enabled by defining IOB_RAM_SP_BE_RMW_ERRINJ_EN.
module iob_ram_sp_be_rmw #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cke_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  perr_o,
  input  logic                  inj_i
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic {IDLE = 1'b0, RMW = 1'b1} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  par_mem;

  logic [ADDR_W-1:0] lat_addr;
  logic [STRB_W-1:0] lat_strb;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_inj;
  logic [DATA_W-1:0] ram_q;
  logic              ram_p;
  logic              rd_par;
  logic [DATA_W-1:0] merged;
  logic              inj_eff;

`ifdef IOB_RAM_SP_BE_RMW_ERRINJ_EN
  assign inj_eff = inj_i;
`else
  logic unused_inj;
  assign unused_inj = inj_i;
  assign inj_eff    = 1'b0;
`endif

  logic accept, is_rd, is_full, rd_acc, full_acc, part_acc, rmw_wr;
  assign accept   = cke_i & valid_i & ready_o;
  assign is_rd    = (wstrb_i == '0);
  assign is_full  = &wstrb_i;
  assign rd_acc   = accept & is_rd;
  assign full_acc = accept & is_full;
  assign part_acc = accept & ~is_rd & ~is_full;
  assign rmw_wr   = cke_i & (state == RMW);

  // Byte merge of latched write data over the old word
  always_comb begin
    merged = ram_q;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (lat_strb[b]) merged[b*8 +: 8] = lat_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cke_i) begin
      case (state)
        IDLE:    if (part_acc) state_nxt = RMW;
        RMW:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = (state == IDLE);
  end

  // Storage and RMW capture are not reset; reset forces IDLE so a pending RMW write is dropped
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (full_acc) begin
        mem[addr_i]     <= wdata_i;
        par_mem[addr_i] <= (^wdata_i) ^ inj_eff;
      end else if (rmw_wr) begin
        mem[lat_addr]     <= merged;
        par_mem[lat_addr] <= (^merged) ^ lat_inj;
      end
      if (part_acc) begin
        lat_addr  <= addr_i;
        lat_strb  <= wstrb_i;
        lat_wdata <= wdata_i;
        lat_inj   <= inj_eff;
        ram_q     <= mem[addr_i];
        ram_p     <= par_mem[addr_i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      rd_par   <= 1'b0;
    end else if (cke_i) begin
      rvalid_o <= rd_acc;
      if (rd_acc) begin
        rdata_o <= mem[addr_i];
        rd_par  <= par_mem[addr_i];
      end
    end
  end

  // Parity check is combinational on the read register or the RMW old word
  assign perr_o = (rvalid_o & ((^rdata_o) ^ rd_par)) |
                  ((state == RMW) & ((^ram_q) ^ ram_p));

endmodule

// File: tb/tb_iob_ram_sp_be_rmw.sv
// Randomized self-checking bench for iob_ram_sp_be_rmw against a word-level memory model.
module tb_iob_ram_sp_be_rmw;
  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        cke_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  addr_i;
  logic [3:0]  wstrb_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        perr_o;
  logic        inj_i;

  iob_ram_sp_be_rmw #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .valid_i(valid_i),
    .ready_o(ready_o), .addr_i(addr_i), .wstrb_i(wstrb_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .perr_o(perr_o), .inj_i(inj_i)
  );

  always #5 clk_i = ~clk_i;

  int npass = 0;
  int ntot  = 0;

  // Model state: memory words, "stored parity is wrong" flags, pending partial write
  logic [31:0] m_mem [16];
  bit          m_bad [16];
  bit          m_busy;
  logic [3:0]  m_pa;
  logic [3:0]  m_ps;
  logic [31:0] m_pd;
  bit          m_pinj;
  bit          e_rvalid;
  logic [31:0] e_rdata;
  bit          e_perr;
  int          bubbles;

`ifdef IOB_RAM_SP_BE_RMW_ERRINJ_EN
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic check_outputs();
    chk("ready", 32'(ready_o), 32'(!m_busy));
    chk("rvalid", 32'(rvalid_o), 32'(e_rvalid));
    chk("rdata", rdata_o, e_rdata);
    if (e_rvalid || m_busy) chk("perr", 32'(perr_o), 32'(e_perr));
  endtask

  // One clock: drive at negedge, advance model, check #1 after the posedge
  task automatic cyc(input bit v, input logic [3:0] a, input logic [3:0] s,
                     input logic [31:0] d, input bit inj, input bit ck);
    valid_i = v; addr_i = a; wstrb_i = s; wdata_i = d; inj_i = inj; cke_i = ck;
    if (ck) begin
      if (m_busy) begin
        m_mem[m_pa] = merge(m_mem[m_pa], m_pd, m_ps);
        m_bad[m_pa] = m_pinj;
        m_busy = 0; e_rvalid = 0; e_perr = 0;
      end else if (v) begin
        if (s == 4'h0) begin
          e_rvalid = 1; e_rdata = m_mem[a]; e_perr = m_bad[a];
        end else if (s == 4'hF) begin
          m_mem[a] = d; m_bad[a] = inj & INJ_ON; e_rvalid = 0; e_perr = 0;
        end else begin
          m_busy = 1; m_pa = a; m_ps = s; m_pd = d; m_pinj = inj & INJ_ON;
          e_rvalid = 0; e_perr = m_bad[a];
          bubbles++;
        end
      end else begin
        e_rvalid = 0; e_perr = 0;
      end
    end
    @(posedge clk_i); #1;
    check_outputs();
    @(negedge clk_i);
  endtask

  task automatic model_reset();
    m_busy = 0; e_rvalid = 0; e_rdata = '0; e_perr = 0;
  endtask

  initial begin
    arst_i = 1'b1; cke_i = 1'b1; valid_i = 1'b0; addr_i = '0; wstrb_i = '0;
    wdata_i = '0; inj_i = 1'b0; bubbles = 0;
    for (int i = 0; i < 16; i++) begin m_mem[i] = '0; m_bad[i] = 0; end
    model_reset();
    @(posedge clk_i); #1;
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_rvalid", 32'(rvalid_o), 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_perr", 32'(perr_o), 32'd0);
    @(negedge clk_i);
    arst_i = 1'b0;

    // Fill memory, then back-to-back reads with literal data pins
    for (int i = 0; i < 16; i++) cyc(1, 4'(i), 4'hF, 32'h20 + 32'(i), 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 4'(i), 4'h0, '0, 0, 1);
      chk("seq_rd_lit", rdata_o, 32'h20 + 32'(i));
      chk("seq_rd_perr", 32'(perr_o), 32'd0);
    end

    // Partial write merge with one-cycle bubble
    cyc(1, 4'd3, 4'hF, 32'hAABBCCDD, 0, 1);
    cyc(1, 4'd3, 4'b0101, 32'h11223344, 0, 1);
    chk("rmw_bubble", 32'(ready_o), 32'd0);
    cyc(0, 4'd0, 4'h0, '0, 0, 1);
    chk("rmw_ready_back", 32'(ready_o), 32'd1);
    cyc(1, 4'd3, 4'h0, '0, 0, 1);
    chk("rmw_merge_lit", rdata_o, 32'hAA22CC44);

`ifdef IOB_RAM_SP_BE_RMW_ERRINJ_EN
    cyc(1, 4'd5, 4'hF, 32'h12345678, 1, 1);
    cyc(1, 4'd5, 4'h0, '0, 0, 1);
    chk("inj_perr_lit", 32'(perr_o), 32'd1);
    chk("inj_data_lit", rdata_o, 32'h12345678);
    cyc(1, 4'd5, 4'b0001, 32'h000000AB, 0, 1);
    chk("inj_rmw_perr_lit", 32'(perr_o), 32'd1);
    cyc(0, 4'd0, 4'h0, '0, 0, 1);
    cyc(1, 4'd5, 4'h0, '0, 0, 1);
    chk("inj_fixed_perr_lit", 32'(perr_o), 32'd0);
    chk("inj_fixed_data_lit", rdata_o, 32'h123456AB);
`endif

    // Alternating full write / read with no bubbles
    for (int i = 0; i < 8; i++) begin
      cyc(1, 4'(i + 8), 4'hF, 32'hC0DE0000 + 32'(i), 0, 1);
      cyc(1, 4'(i + 8), 4'h0, '0, 0, 1);
      chk("alt_rd_lit", rdata_o, 32'hC0DE0000 + 32'(i));
    end

    // Reset during the RMW cycle drops the pending write
    cyc(1, 4'd7, 4'hF, 32'h0, 0, 1);
    cyc(1, 4'd7, 4'b0011, 32'hFFFFFFFF, 0, 1);
    arst_i = 1'b1; valid_i = 1'b0;
    model_reset();
    #1;
    chk("arst_rvalid", 32'(rvalid_o), 32'd0);
    chk("arst_rdata", rdata_o, 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    check_outputs();
    @(negedge clk_i);
    arst_i = 1'b0;
    cyc(1, 4'd7, 4'h0, '0, 0, 1);
    chk("arst_mem_lit", rdata_o, 32'h0);

    // Clock enable low freezes everything
    cyc(1, 4'd2, 4'h0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 4'd2, 4'hF, 32'hDEADBEEF, 0, 0);
    chk("cke_hold_rvalid", 32'(rvalid_o), 32'd1);
    cyc(1, 4'd2, 4'h0, '0, 0, 1);
    chk("cke_mem_lit", rdata_o, 32'h22);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] s;
      int r;
      r = int'($urandom_range(0, 2));
      s = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom);
      cyc(bit'($urandom_range(0, 3) != 0), 4'($urandom), s, $urandom,
          bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 9) != 0));
    end
    cyc(0, 4'd0, 4'h0, '0, 0, 1);
    if (bubbles < 5) begin
      ntot++;
      $display("FAIL coverage: partial writes %0d required at least 5", bubbles);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
